// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

  typedef enum logic [1:0] {
    REQ,
    WAIT,
    HOLD,
    DROP
  } fetch_state_e;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline latch: PC, instruction and valid bit with load and flush.
module if_id_reg
  import fetch_pkg::*;
#(
  parameter int unsigned PC_W = 9
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            flush,
  input  logic [PC_W-1:0] pc_in,
  input  logic [31:0]     instr_in,
  output logic [PC_W-1:0] pc,
  output logic [31:0]     instr,
  output logic            valid
);

  // Flush wins over load so a redirect can never leak a wrong-path word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc    <= '0;
      instr <= NOP_INSTR;
      valid <= 1'b0;
    end else if (flush) begin
      pc    <= '0;
      instr <= NOP_INSTR;
      valid <= 1'b0;
    end else if (load) begin
      pc    <= pc_in;
      instr <= instr_in;
      valid <= 1'b1;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// IF stage: PC register, single-outstanding instruction fetch FSM, hold buffer
// for words returned under stall, and redirect handling from the branch unit.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter int unsigned     PC_W     = 9,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            Stall,
  input  logic            PcSel,
  input  logic [31:0]     BrPC,
  output logic            ImemReq,
  output logic [PC_W-1:0] ImemAddr,
  input  logic [31:0]     ImemRdata,
  input  logic            ImemValid,
  output logic [PC_W-1:0] IdPC,
  output logic [31:0]     IdInstr,
  output logic            IdValid
);

  fetch_state_e    state, next_state;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [31:0]     hold_q, hold_d;
  logic            id_load, id_flush;
  logic [31:0]     id_instr_in;
  logic [PC_W-1:0] pc_inc;
  logic [PC_W-1:0] br_target;
  logic            unused_br;

  assign pc_inc    = pc_q + PC_W'(4);
  assign br_target = {BrPC[PC_W-1:2], 2'b00};
  assign unused_br = ^{BrPC[31:PC_W], BrPC[1:0]};

  // A redirect in REQ suppresses that cycle's request, and a redirect in DROP
  // keeps waiting for the stale reply, so at most one fetch is ever in flight.
  assign ImemReq  = (state == REQ) && !reset && !PcSel;
  assign ImemAddr = pc_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= REQ;
      pc_q   <= RESET_PC;
      hold_q <= NOP_INSTR;
    end else begin
      state  <= next_state;
      pc_q   <= pc_d;
      hold_q <= hold_d;
    end
  end

  always_comb begin
    next_state  = state;
    pc_d        = pc_q;
    hold_d      = hold_q;
    id_load     = 1'b0;
    id_flush    = 1'b0;
    id_instr_in = ImemRdata;
    if (PcSel) begin
      pc_d     = br_target;
      id_flush = 1'b1;
      hold_d   = NOP_INSTR;
      if ((state == WAIT || state == DROP) && !ImemValid) next_state = DROP;
      else next_state = REQ;
    end else begin
      case (state)
        REQ: next_state = WAIT;
        WAIT: begin
          if (ImemValid) begin
            if (Stall) begin
              hold_d     = ImemRdata;
              next_state = HOLD;
            end else begin
              id_load    = 1'b1;
              pc_d       = pc_inc;
              next_state = REQ;
            end
          end
        end
        HOLD: begin
          if (!Stall) begin
            id_load     = 1'b1;
            id_instr_in = hold_q;
            pc_d        = pc_inc;
            next_state  = REQ;
          end
        end
        DROP: begin
          if (ImemValid) next_state = REQ;
        end
        default: next_state = REQ;
      endcase
    end
  end

  if_id_reg #(
    .PC_W(PC_W)
  ) u_if_id (
    .clk     (clk),
    .rst     (reset),
    .load    (id_load),
    .flush   (id_flush),
    .pc_in   (pc_q),
    .instr_in(id_instr_in),
    .pc      (IdPC),
    .instr   (IdInstr),
    .valid   (IdValid)
  );

endmodule
